// File: rtl/imem_loader_ctl.sv
// imem_loader_ctl: receives a count/words/checksum byte frame from the UART and writes it into instruction memory
module imem_loader_ctl #(
  parameter int ADDR_W = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              CLK,
  input  logic              CPU_RESETN,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              reload,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [15:0]       imem_wdata,
  output logic              imem_we,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, GET_HI, GET_LO, GET_CSUM, DONE} state_t;
  state_t state;
  logic [ADDR_W:0] n;
  logic [ADDR_W:0] next_words;
  logic [7:0] csum;
  logic [7:0] hi;
  logic [TW-1:0] tmo;
  logic busy;
  logic tmo_hit;
  assign next_words = words_loaded + 1'b1;
  assign busy = (state == GET_HI) || (state == GET_LO) || (state == GET_CSUM);
  assign tmo_hit = tmo == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLK) begin
    if (!CPU_RESETN) begin
      state <= IDLE;
      n <= '0;
      csum <= '0;
      hi <= '0;
      tmo <= '0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      imem_we <= 1'b0;
      load_done <= 1'b0;
      load_error <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (reload) begin
        state <= IDLE;
        load_done <= 1'b0;
        tmo <= '0;
      end else if (busy && !rx_valid) begin
        // an arriving byte in the terminal cycle takes the rx_valid branch instead
        if (tmo_hit) begin
          state <= IDLE;
          load_error <= 1'b1;
          tmo <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else if (rx_valid) begin
        tmo <= '0;
        case (state)
          IDLE: begin
            n <= (rx_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(rx_data);
            csum <= rx_data;
            words_loaded <= '0;
            load_error <= 1'b0;
            state <= GET_HI;
          end
          GET_HI: begin
            hi <= rx_data;
            csum <= csum ^ rx_data;
            state <= GET_LO;
          end
          GET_LO: begin
            csum <= csum ^ rx_data;
            imem_wdata <= {hi, rx_data};
            imem_waddr <= words_loaded[ADDR_W-1:0];
            imem_we <= 1'b1;
            words_loaded <= next_words;
            state <= (next_words == n) ? GET_CSUM : GET_HI;
          end
          GET_CSUM: begin
            if (rx_data == csum) begin
              load_done <= 1'b1;
              state <= DONE;
            end else begin
              load_error <= 1'b1;
              state <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
